// File: rtl/spi_slave_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_frame_pkg
//   Shared definitions for the SPI slave frame receiver/transmitter:
//   FSM state encoding, byte width and a small shift helper.
// -----------------------------------------------------------------------------
package spi_slave_frame_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } spi_state_e;

  // Shift one serial bit into the LSB end of a byte, MSB falls off.
  function automatic logic [SPI_BYTE_W-1:0] shift_in(input logic [SPI_BYTE_W-1:0] sr,
                                                     input logic                  bit_in);
    return {sr[SPI_BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_slave_frame_shift8.sv
// -----------------------------------------------------------------------------
// spi_shift8
//   8-bit shift register with parallel load, serial input at the LSB and the
//   MSB exposed as serial output. Load has priority over shift.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (register clears to 0)
//   load         parallel load strobe, load_data captured
//   load_data    byte to load
//   shift        shift strobe, sin enters at bit 0
//   sin          serial input bit
//   q            full register contents
//   msb          q[7], serial output
// -----------------------------------------------------------------------------
module spi_shift8
  import spi_slave_frame_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SPI_BYTE_W-1:0] load_data,
  input  logic                  shift,
  input  logic                  sin,
  output logic [SPI_BYTE_W-1:0] q,
  output logic                  msb
);

  logic [SPI_BYTE_W-1:0] sr_q;
  logic [SPI_BYTE_W-1:0] sr_d;

  // Next-value selection: load wins over shift, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = shift_in(sr_q, sin);
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= {SPI_BYTE_W{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q   = sr_q;
  assign msb = sr_q[SPI_BYTE_W-1];

endmodule

// File: rtl/spi_slave_frame.sv
// -----------------------------------------------------------------------------
// spi_slave_frame
//   Synchronous SPI slave (SCLK == clk while spi_cs_n is low). Receives MOSI
//   MSB-first into bytes tagged with their frame position, transmits a byte
//   stream on MISO, and flags truncated and over-long frames.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   spi_cs_n, spi_mosi  chip select (active low) and serial data from master
//   spi_miso            serial data to master (TX shifter MSB)
//   tx_data / tx_take   next TX byte, and pulse when it was loaded
//   rx_data/first/index last received byte, command-byte flag, byte position
//   rx_valid            pulse when the rx_* outputs were updated
//   frame_start/end     frame boundary pulses
//   frame_err           with frame_end: frame ended mid-byte
//   frame_ovf           byte completed beyond MAX_BYTES
//   busy                FSM not idle
// -----------------------------------------------------------------------------
module spi_slave_frame
  import spi_slave_frame_pkg::*;
#(
  parameter int MAX_BYTES = 10,
  parameter int IDX_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  tx_take,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  output logic [IDX_W-1:0]      rx_index,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  frame_err,
  output logic                  frame_ovf,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_BYTES);

  spi_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [IDX_W-1:0]      rx_index_q, rx_index_d;
  logic                  rx_first_q, rx_first_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_take_q, tx_take_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_end_q, frame_end_d;
  logic                  frame_err_q, frame_err_d;
  logic                  frame_ovf_q, frame_ovf_d;
  logic                  busy_q, busy_d;

  logic                  rx_shift_s;
  logic                  tx_shift_s;
  logic                  tx_load_s;
  logic [SPI_BYTE_W-1:0] rx_sr_s;
  logic [SPI_BYTE_W-1:0] tx_sr_s;
  logic                  rx_msb_s;
  logic                  tx_msb_s;

  spi_shift8 u_rx_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ({SPI_BYTE_W{1'b0}}),
    .shift     (rx_shift_s),
    .sin       (spi_mosi),
    .q         (rx_sr_s),
    .msb       (rx_msb_s)
  );

  spi_shift8 u_tx_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load_s),
    .load_data (tx_data),
    .shift     (tx_shift_s),
    .sin       (1'b0),
    .q         (tx_sr_s),
    .msb       (tx_msb_s)
  );

  // Next-state, counter and pulse logic for the frame FSM.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    rx_data_d     = rx_data_q;
    rx_index_d    = rx_index_q;
    rx_first_d    = rx_first_q;
    rx_valid_d    = 1'b0;
    tx_take_d     = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_err_d   = 1'b0;
    frame_ovf_d   = 1'b0;
    rx_shift_s    = 1'b0;
    tx_shift_s    = 1'b0;
    tx_load_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!spi_cs_n) begin
          // First bit of the frame: the preloaded byte's MSB was just sampled.
          rx_shift_s    = 1'b1;
          tx_shift_s    = 1'b1;
          bit_cnt_d     = 3'd1;
          byte_cnt_d    = {IDX_W{1'b0}};
          frame_start_d = 1'b1;
          tx_take_d     = 1'b1;
          state_d       = ST_SHIFT;
        end else begin
          // Keep MISO bit 7 primed with whatever the source currently offers.
          tx_load_s = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (!spi_cs_n) begin
          rx_shift_s = 1'b1;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Byte boundary: next TX byte must be in place before the next edge.
            tx_load_s = 1'b1;
            tx_take_d = 1'b1;
            if (byte_cnt_q == MAX_CNT) begin
              frame_ovf_d = 1'b1;
            end else begin
              rx_data_d  = shift_in(rx_sr_s, spi_mosi);
              rx_index_d = byte_cnt_q;
              rx_first_d = (byte_cnt_q == {IDX_W{1'b0}});
              rx_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end else begin
            tx_shift_s = 1'b1;
          end
        end else begin
          // Frame over; reload TX so a back-to-back frame starts with fresh data.
          frame_end_d = 1'b1;
          frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
          tx_load_s   = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (spi_cs_n) begin
          bit_cnt_d = 3'd0;
          tx_load_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_DRAIN;
      end
    endcase

    // Registered so busy reads 0 during reset even though reset lands in DRAIN.
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_DRAIN;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= {IDX_W{1'b0}};
      rx_data_q     <= {SPI_BYTE_W{1'b0}};
      rx_index_q    <= {IDX_W{1'b0}};
      rx_first_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_take_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_ovf_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_index_q    <= rx_index_d;
      rx_first_q    <= rx_first_d;
      rx_valid_q    <= rx_valid_d;
      tx_take_q     <= tx_take_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
      frame_ovf_q   <= frame_ovf_d;
      busy_q        <= busy_d;
    end
  end

  assign spi_miso    = tx_msb_s;
  assign tx_take     = tx_take_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_first    = rx_first_q;
  assign rx_index    = rx_index_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_err   = frame_err_q;
  assign frame_ovf   = frame_ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_frame
//   Simulated SPI master plus scoreboard. The master pushes expected events
//   (received bytes, frame boundaries, overflow) with their expected cycle;
//   a monitor pops and compares whenever the DUT pulses an output.
// -----------------------------------------------------------------------------
module tb_spi_slave_frame;

  localparam int MAX_BYTES = 10;
  localparam int IDX_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;
  logic [7:0]       tx_data;
  logic             tx_take;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_first;
  logic [IDX_W-1:0] rx_index;
  logic             frame_start;
  logic             frame_end;
  logic             frame_err;
  logic             frame_ovf;
  logic             busy;

  spi_slave_frame #(.MAX_BYTES(MAX_BYTES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_take(tx_take),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .rx_index(rx_index), .frame_start(frame_start), .frame_end(frame_end),
    .frame_err(frame_err), .frame_ovf(frame_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         idx;
    logic       first;
    int         at;
  } rx_exp_t;

  typedef struct {
    int   at;
    logic err;
  } end_exp_t;

  rx_exp_t  rx_q[$];
  end_exp_t end_q[$];
  int       start_q[$];
  int       ovf_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] vals [0:1023];   // TX byte source, consumed one per tx_take
  int         take_cnt = 0;    // takes seen by the source
  int         tx_base  = 0;    // model: values consumed by frames so far
  logic [7:0] fb [0:15];       // bytes the master sends in the current frame

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // TX byte source: advances to the next byte whenever the DUT takes one.
  initial begin
    for (int i = 0; i < 1024; i++) vals[i] = 8'($urandom);
    tx_data = vals[0];
    forever begin
      @(negedge clk);
      if (tx_take === 1'b1) begin
        take_cnt++;
        tx_data = vals[take_cnt & 1023];
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (rx_q.size() == 0) chk("rx_unexpected", 32'(rx_valid), 32'd0);
        else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          chk("rx_data",  32'(rx_data),  32'(e.data));
          chk("rx_index", 32'(rx_index), 32'(e.idx));
          chk("rx_first", 32'(rx_first), 32'(e.first));
          chk("rx_cycle", 32'(cyc),      32'(e.at));
        end
      end
      if (frame_start === 1'b1) begin
        if (start_q.size() == 0) chk("start_unexpected", 32'(frame_start), 32'd0);
        else chk("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
      end
      if (frame_end === 1'b1) begin
        if (end_q.size() == 0) chk("end_unexpected", 32'(frame_end), 32'd0);
        else begin
          end_exp_t e;
          e = end_q.pop_front();
          chk("end_cycle", 32'(cyc),       32'(e.at));
          chk("frame_err", 32'(frame_err), 32'(e.err));
        end
      end else if (frame_err === 1'b1) begin
        chk("err_without_end", 32'(frame_err), 32'd0);
      end
      if (frame_ovf === 1'b1) begin
        if (ovf_q.size() == 0) chk("ovf_unexpected", 32'(frame_ovf), 32'd0);
        else chk("ovf_cycle", 32'(cyc), 32'(ovf_q.pop_front()));
      end
    end
  end

  // Master: send nbits of fb[] MSB first, then hold cs_n high for gap cycles.
  // rst_at >= 0 pulses reset during that bit; the rest of the frame is ignored.
  task automatic run_frame(input int nbits, input int gap, input int rst_at);
    logic [7:0] cap [0:15];
    bit         reset_seen = 1'b0;
    int         ncomp;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi_cs_n = 1'b0;
      spi_mosi = fb[i/8][7 - (i % 8)];
      cap[i/8][7 - (i % 8)] = spi_miso;
      if (i == rst_at) begin
        rst = 1'b1;
        reset_seen = 1'b1;
      end else begin
        rst = 1'b0;
      end
      if (!reset_seen) begin
        if (i == 0) start_q.push_back(cyc + 1);
        if ((i % 8) == 7) begin
          if ((i / 8) < MAX_BYTES) begin
            rx_exp_t e;
            e.data  = fb[i/8];
            e.idx   = i / 8;
            e.first = ((i / 8) == 0);
            e.at    = cyc + 1;
            rx_q.push_back(e);
          end else begin
            ovf_q.push_back(cyc + 1);
          end
        end
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rst      = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'($urandom);
      if (g == 0 && !reset_seen) begin
        end_exp_t e;
        e.at  = cyc + 1;
        e.err = ((nbits % 8) != 0);
        end_q.push_back(e);
      end
    end
    ncomp = nbits / 8;
    if (reset_seen) begin
      tx_base += 1;
    end else begin
      for (int k = 0; k < ncomp; k++)
        chk($sformatf("miso_byte%0d", k), 32'(cap[k]), 32'(vals[(tx_base + k) & 1023]));
      tx_base += ncomp + 1;
    end
  endtask

  task automatic set_bytes3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    fb[0] = b0; fb[1] = b1; fb[2] = b2;
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data",  32'(rx_data),  32'd0);
    chk("reset_rx_index", 32'(rx_index), 32'd0);
    chk("reset_pulses",   32'({rx_valid, rx_first, tx_take, frame_start,
                                frame_end, frame_err, frame_ovf}), 32'd0);
    chk("reset_miso",     32'(spi_miso), 32'd0);
    chk("reset_busy",     32'(busy),     32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Three-byte command frame.
    set_bytes3(8'hA5, 8'h3C, 8'hFF);
    run_frame(24, 2, -1);
    // Two-byte frame, MISO checked against the TX source.
    rand_bytes();
    run_frame(16, 2, -1);
    // Truncated frame: 12 bits.
    set_bytes3(8'hA5, 8'hF0, 8'h00);
    run_frame(12, 2, -1);
    // Over-long frame: two bytes past MAX_BYTES.
    rand_bytes();
    run_frame(8 * (MAX_BYTES + 2), 2, -1);
    // Reset during bit 5 of a 4-byte frame, then a clean 5A frame.
    rand_bytes();
    run_frame(32, 2, 4);
    fb[0] = 8'h5A;
    run_frame(8, 2, -1);
    // Back-to-back single-byte frames with one cs_n-high cycle between.
    fb[0] = 8'hC3;
    run_frame(8, 1, -1);
    fb[0] = 8'h3C;
    run_frame(8, 2, -1);
    // Random frames of random length and gap.
    for (int f = 0; f < 20; f++) begin
      rand_bytes();
      run_frame($urandom_range(1, 8 * (MAX_BYTES + 3)), $urandom_range(1, 3), -1);
    end

    repeat (4) @(negedge clk);
    chk("rx_pending",    32'(rx_q.size()),    32'd0);
    chk("end_pending",   32'(end_q.size()),   32'd0);
    chk("start_pending", 32'(start_q.size()), 32'd0);
    chk("ovf_pending",   32'(ovf_q.size()),   32'd0);
    chk("take_count",    32'(take_cnt),       32'(tx_base));
    chk("final_busy",    32'(busy),           32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
